mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port data/instruction memory between two requesters: the instruction-fetch stage (I port) and the load/store stage (D port). Grants one access at a time, drives the memory address/data/write controls, counts out a fixed memory wait time, and returns read data with a one-cycle acknowledge. It sits between the PC/instruction-fetch logic, the ALU/register datapath, and the Memory block, and is sequenced by the main CONTROL outputs (MEMW, HALT).

Parameters:
WAIT_CYCLES, 1, extra memory cycles per access beyond the first (0..15)
STARVE_LIMIT, 3, consecutive D grants allowed while I is pending before I is forced (1..15)

Ports:
CLOCK  input  1  system clock, rising edge
CLEAR  input  1  asynchronous active-low reset
halt  input  1  CONTROL HALT; blocks new I grants while high
i_req  input  1  fetch request; held until i_ack
i_addr  input  16  fetch address (PC)
i_ack  output  1  one-cycle pulse: i_rdata valid
i_rdata  output  16  fetched instruction word
d_req  input  1  load/store request; held until d_ack
d_memw  input  2  00 read, 01 word write, 10 byte write, 11 treated as read
d_addr  input  16  data address (ALU result)
d_wdata  input  16  store data; byte writes use [7:0]
d_ack  output  1  one-cycle pulse: access done, d_rdata valid for reads
d_rdata  output  16  load data word
mem_en  output  1  memory access active
mem_addr  output  16  memory address
mem_wdata  output  16  memory write data
mem_we  output  2  memory write control, MEMW encoding
mem_rdata  input  16  memory read word
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock (CLOCK); reset CLEAR is asynchronous and active-low. While CLEAR=0: state IDLE; all outputs 0, including i_ack, d_ack, i_rdata, d_rdata, mem_en, mem_addr, mem_wdata, mem_we=00, and busy; wait counter and streak counter 0.
- CLEAR asserted mid-access abandons the access. No ack is issued, and mem_we drops to 00 immediately.
- States are IDLE, ACCESS, and RESP.
- IDLE:
  - Eligible requests are d_req, and i_req only when halt=0.
  - If none is eligible, stay in IDLE.
  - Otherwise grant one requester at the clock edge. Latch the owner, address, wdata and write code into mem_* registers. Set mem_en=1 and load wait counter = WAIT_CYCLES. Go to ACCESS.
- Priority:
  - D wins over I by default.
  - If I is eligible and streak == STARVE_LIMIT, I wins.
  - Streak increments on each D grant made while I is eligible (saturating at STARVE_LIMIT).
  - Streak clears on any I grant, and at any IDLE edge where I is not eligible.
- ACCESS:
  - mem_we holds the latched write code for the first ACCESS cycle only, then 00, so the memory sees one write.
  - mem_addr and mem_wdata are held stable for the whole state.
  - Counter decrements each edge.
  - At the edge where counter==0: register mem_rdata into the owner's rdata, set the owner's ack=1, clear mem_en, and go to RESP.
- RESP: exactly one cycle with the ack high. No grant is made in this state, so the requester drops req during this cycle. Next edge: ack=0, go to IDLE.
- Latency: request sampled at edge t0 → ack high from edge t0+1+WAIT_CYCLES for one cycle. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- rdata registers hold their value until that port's next completed access.
  - For writes, d_rdata captures mem_rdata anyway; its value is don't-care.
  - The i_rdata register is never altered by D accesses, and vice versa.
- d_memw=11 is treated as a read (mem_we=00).
- halt rising during an I access does not abort it; the access completes and acks normally.
- Simultaneous i_req and d_req in IDLE: resolved by the priority rules only; the losing request stays pending without error.
- Request inputs are sampled only in IDLE. Changes to addr/data after grant have no effect on the access in flight.

Test Plan:
- Reset/idle: CLEAR=0 mid-ACCESS with d_memw=01 → mem_we=00, mem_en=0, busy=0, no d_ack. After CLEAR=1 with no requests, outputs stay 0.
- Single fetch, WAIT_CYCLES=1: i_req with i_addr=0x0004, mem_rdata=0x1234 → mem_addr=0x0004 for 2 cycles, i_ack one cycle at t0+2, i_rdata=0x1234.
- Word write then read: d_memw=01, d_addr=0x0010, d_wdata=0xBEEF → mem_we=01 for exactly 1 cycle. Then d_memw=00 at the same address with mem_rdata=0xBEEF → d_rdata=0xBEEF.
- Contention/starvation, STARVE_LIMIT=3: i_req and d_req held continuously, each re-requesting after its ack → grant order D,D,D,I,D,D,D,I…; neither port starves.
- Halt: halt=1 with i_req only → no grant, busy=0. Add d_req → D served. Drop halt → I granted at the next IDLE edge.
- Byte write and illegal code: d_memw=10, d_wdata=0x00AB → mem_we=10, mem_wdata[7:0]=0xAB. Then d_memw=11 → mem_we stays 00 and d_ack occurs normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester single-port memory arbiter (fetch vs load/store)
//
// Shares one memory between the instruction-fetch port (I) and the load/store
// port (D). One access at a time: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP
// (one-cycle ack) -> IDLE. D has priority; I is forced after STARVE_LIMIT
// consecutive D grants made while I was waiting.
//
// Ports:
//   CLOCK, CLEAR          clock (rising edge), asynchronous active-low reset
//   halt                  blocks new I grants while high
//   i_req/i_addr          fetch request and address; i_ack/i_rdata response
//   d_req/d_memw/d_addr/d_wdata  load/store request; d_ack/d_rdata response
//   mem_en/mem_addr/mem_wdata/mem_we  memory controls; mem_rdata read word
//   busy                  high whenever the arbiter is not in IDLE
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        CLOCK,
  input  logic        CLEAR,
  input  logic        halt,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic [1:0]  d_memw,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_we,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        owner_d_q, owner_d_d;   // 1: current access belongs to D
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_en_q, mem_en_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_we_q, mem_we_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic i_elig;
  logic i_forced;

  assign i_elig   = i_req & ~halt;
  assign i_forced = i_elig && (streak_q == STREAK_MAX);

  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      wait_q      <= 4'd0;
      streak_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      mem_we_q    <= 2'b00;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= 16'h0000;
      d_rdata_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      wait_q      <= wait_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    wait_d      = wait_q;
    streak_d    = streak_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          owner_d_d   = 1'b1;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Code 11 is not a write; present it to memory as a read.
          mem_we_d    = (d_memw == 2'b11) ? 2'b00 : d_memw;
          mem_en_d    = 1'b1;
          wait_d      = WAIT_INIT;
          state_d     = ACCESS;
          // Only D grants that overtake a waiting I count toward starvation.
          if (i_elig) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end else if (i_elig) begin
          owner_d_d   = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = 16'h0000;
          mem_we_d    = 2'b00;
          mem_en_d    = 1'b1;
          wait_d      = WAIT_INIT;
          state_d     = ACCESS;
          streak_d    = 4'd0;
        end else begin
          streak_d = 4'd0;
        end
      end

      ACCESS: begin
        // Write strobe lasts only the first ACCESS cycle: one write per access.
        mem_we_d = 2'b00;
        if (wait_q == 4'd0) begin
          if (owner_d_q) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_ack_d   = 1'b1;
          end
          mem_en_d = 1'b0;
          state_d  = RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        CLOCK;
  logic        CLEAR;
  logic        halt;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req;
  logic [1:0]  d_memw;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_we;
  logic [15:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(3)) dut (
    .CLOCK(CLOCK), .CLEAR(CLEAR), .halt(halt),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_memw(d_memw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // {i_ack, d_ack, busy, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata}
  logic [69:0] act;
  assign act = {i_ack, d_ack, busy, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata};

  typedef struct {
    logic        i_req;
    logic [15:0] i_addr;
    logic        halt;
    logic        d_req;
    logic [1:0]  d_memw;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] mem_rdata;
    logic [69:0] exp;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic ir, input logic [15:0] ia, input logic hl,
                     input logic dr, input logic [1:0] dm, input logic [15:0] da,
                     input logic [15:0] dw, input logic [15:0] mr,
                     input logic e_ia, input logic e_da, input logic e_bz,
                     input logic e_en, input logic [1:0] e_we, input logic [15:0] e_ad,
                     input logic [15:0] e_wd, input logic [15:0] e_ir,
                     input logic [15:0] e_dr);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.halt = hl; v.d_req = dr; v.d_memw = dm;
    v.d_addr = da; v.d_wdata = dw; v.mem_rdata = mr;
    v.exp = {e_ia, e_da, e_bz, e_en, e_we, e_ad, e_wd, e_ir, e_dr};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  int          n;
  int          cyc;
  logic [1:0]  order[8];
  logic        both_ack;
  logic        seen_ack;

  initial begin
    CLEAR = 1'b0; halt = 1'b0; i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0;
    d_memw = 2'b00; d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0;

    //   ir ia       hl dr dm     da       dw       mr        ia da bz en we     addr     wdata    i_rdata  d_rdata
    // single fetch
    add(1, 16'h0004, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 0, 0, 1, 1, 2'b00, 16'h0004, 16'h0000, 16'h0000, 16'h0000);
    add(1, 16'h0004, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 0, 0, 1, 1, 2'b00, 16'h0004, 16'h0000, 16'h0000, 16'h0000);
    add(1, 16'h0004, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 1, 0, 1, 0, 2'b00, 16'h0004, 16'h0000, 16'h1234, 16'h0000);
    add(0, 16'h0004, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 0, 2'b00, 16'h0004, 16'h0000, 16'h1234, 16'h0000);
    add(0, 16'h0004, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 0, 2'b00, 16'h0004, 16'h0000, 16'h1234, 16'h0000);
    // word write
    add(0, 16'h0000, 0, 1, 2'b01, 16'h0010, 16'hBEEF, 16'h0000, 0, 0, 1, 1, 2'b01, 16'h0010, 16'hBEEF, 16'h1234, 16'h0000);
    add(0, 16'h0000, 0, 1, 2'b01, 16'h0010, 16'hBEEF, 16'h0000, 0, 0, 1, 1, 2'b00, 16'h0010, 16'hBEEF, 16'h1234, 16'h0000);
    add(0, 16'h0000, 0, 1, 2'b01, 16'h0010, 16'hBEEF, 16'h0000, 0, 1, 1, 0, 2'b00, 16'h0010, 16'hBEEF, 16'h1234, 16'h0000);
    add(0, 16'h0000, 0, 0, 2'b01, 16'h0010, 16'hBEEF, 16'h0000, 0, 0, 0, 0, 2'b00, 16'h0010, 16'hBEEF, 16'h1234, 16'h0000);
    // read back
    add(0, 16'h0000, 0, 1, 2'b00, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 1, 2'b00, 16'h0010, 16'h0000, 16'h1234, 16'h0000);
    add(0, 16'h0000, 0, 1, 2'b00, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 1, 2'b00, 16'h0010, 16'h0000, 16'h1234, 16'h0000);
    add(0, 16'h0000, 0, 1, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 0, 1, 1, 0, 2'b00, 16'h0010, 16'h0000, 16'h1234, 16'hBEEF);
    add(0, 16'h0000, 0, 0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 2'b00, 16'h0010, 16'h0000, 16'h1234, 16'hBEEF);
    // byte write
    add(0, 16'h0000, 0, 1, 2'b10, 16'h0020, 16'h00AB, 16'hBEEF, 0, 0, 1, 1, 2'b10, 16'h0020, 16'h00AB, 16'h1234, 16'hBEEF);
    add(0, 16'h0000, 0, 1, 2'b10, 16'h0020, 16'h00AB, 16'hBEEF, 0, 0, 1, 1, 2'b00, 16'h0020, 16'h00AB, 16'h1234, 16'hBEEF);
    add(0, 16'h0000, 0, 1, 2'b10, 16'h0020, 16'h00AB, 16'hBEEF, 0, 1, 1, 0, 2'b00, 16'h0020, 16'h00AB, 16'h1234, 16'hBEEF);
    add(0, 16'h0000, 0, 0, 2'b10, 16'h0020, 16'h00AB, 16'hBEEF, 0, 0, 0, 0, 2'b00, 16'h0020, 16'h00AB, 16'h1234, 16'hBEEF);
    // code 11 behaves as a read
    add(0, 16'h0000, 0, 1, 2'b11, 16'h0030, 16'h1111, 16'h4321, 0, 0, 1, 1, 2'b00, 16'h0030, 16'h1111, 16'h1234, 16'hBEEF);
    add(0, 16'h0000, 0, 1, 2'b11, 16'h0030, 16'h1111, 16'h4321, 0, 0, 1, 1, 2'b00, 16'h0030, 16'h1111, 16'h1234, 16'hBEEF);
    add(0, 16'h0000, 0, 1, 2'b11, 16'h0030, 16'h1111, 16'h4321, 0, 1, 1, 0, 2'b00, 16'h0030, 16'h1111, 16'h1234, 16'h4321);
    add(0, 16'h0000, 0, 0, 2'b11, 16'h0030, 16'h1111, 16'h4321, 0, 0, 0, 0, 2'b00, 16'h0030, 16'h1111, 16'h1234, 16'h4321);
    // halt blocks I, D still served, I granted once halt drops
    add(1, 16'h0040, 1, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 2'b00, 16'h0030, 16'h1111, 16'h1234, 16'h4321);
    add(1, 16'h0040, 1, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 2'b00, 16'h0030, 16'h1111, 16'h1234, 16'h4321);
    add(1, 16'h0040, 1, 1, 2'b00, 16'h0050, 16'h0000, 16'h9999, 0, 0, 1, 1, 2'b00, 16'h0050, 16'h0000, 16'h1234, 16'h4321);
    add(1, 16'h0040, 1, 1, 2'b00, 16'h0050, 16'h0000, 16'h9999, 0, 0, 1, 1, 2'b00, 16'h0050, 16'h0000, 16'h1234, 16'h4321);
    add(1, 16'h0040, 1, 1, 2'b00, 16'h0050, 16'h0000, 16'h9999, 0, 1, 1, 0, 2'b00, 16'h0050, 16'h0000, 16'h1234, 16'h9999);
    add(1, 16'h0040, 1, 0, 2'b00, 16'h0050, 16'h0000, 16'h9999, 0, 0, 0, 0, 2'b00, 16'h0050, 16'h0000, 16'h1234, 16'h9999);
    add(1, 16'h0040, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0A0A, 0, 0, 1, 1, 2'b00, 16'h0040, 16'h0000, 16'h1234, 16'h9999);
    add(1, 16'h0040, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0A0A, 0, 0, 1, 1, 2'b00, 16'h0040, 16'h0000, 16'h1234, 16'h9999);
    add(1, 16'h0040, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0A0A, 1, 0, 1, 0, 2'b00, 16'h0040, 16'h0000, 16'h0A0A, 16'h9999);
    add(0, 16'h0040, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0A0A, 0, 0, 0, 0, 2'b00, 16'h0040, 16'h0000, 16'h0A0A, 16'h9999);

    // Reset state
    tick();
    tick();
    chk("reset_outputs", act, 70'd0);
    CLEAR = 1'b1;
    tick();
    chk("idle_after_reset", act, 70'd0);

    // Table-driven vectors
    for (int k = 0; k < vq.size(); k++) begin
      i_req = vq[k].i_req; i_addr = vq[k].i_addr; halt = vq[k].halt;
      d_req = vq[k].d_req; d_memw = vq[k].d_memw; d_addr = vq[k].d_addr;
      d_wdata = vq[k].d_wdata; mem_rdata = vq[k].mem_rdata;
      tick();
      chk($sformatf("vec%0d", k), act, vq[k].exp);
    end

    // Contention: both ports re-request after every ack; expect D,D,D,I repeating
    for (int k = 0; k < 8; k++) order[k] = 2'd2;
    halt = 1'b0; d_memw = 2'b00; i_addr = 16'h0100; d_addr = 16'h0200;
    mem_rdata = 16'h0000; i_req = 1'b1; d_req = 1'b1;
    n = 0; cyc = 0; both_ack = 1'b0;
    while (n < 8 && cyc < 200) begin
      tick();
      cyc++;
      if (i_ack && d_ack) both_ack = 1'b1;
      if (i_ack) begin
        if (n < 8) order[n] = 2'd0;
        n++;
        i_req = 1'b0;
      end else begin
        i_req = 1'b1;
      end
      if (d_ack) begin
        if (n < 8) order[n] = 2'd1;
        n++;
        d_req = 1'b0;
      end else begin
        d_req = 1'b1;
      end
    end
    chk("contention_no_double_ack", 70'(both_ack), 70'd0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("grant_order%0d", k), 70'(order[k]), (k % 4 == 3) ? 70'd0 : 70'd1);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Reset in the middle of a word-write access
    d_req = 1'b1; d_memw = 2'b01; d_addr = 16'h0300; d_wdata = 16'h5A5A;
    tick();
    chk("midreset_pre_we", 70'(mem_we), 70'd1);
    #2;
    CLEAR = 1'b0;
    #1;
    chk("midreset_async", 70'({mem_we, mem_en, busy, d_ack}), 70'd0);
    d_req = 1'b0;
    seen_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (d_ack || i_ack) seen_ack = 1'b1;
    end
    CLEAR = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (d_ack || i_ack) seen_ack = 1'b1;
    end
    chk("midreset_no_ack", 70'(seen_ack), 70'd0);
    chk("midreset_idle_zero", act, 70'd0);

    // halt rising during an I access does not abort it
    i_req = 1'b1; i_addr = 16'h0400; mem_rdata = 16'h7E7E;
    tick();
    halt = 1'b1;
    seen_ack = 1'b0;
    cyc = 0;
    while (!seen_ack && cyc < 10) begin
      tick();
      cyc++;
      if (i_ack) seen_ack = 1'b1;
    end
    i_req = 1'b0;
    chk("halt_mid_fetch_ack", 70'(seen_ack), 70'd1);
    chk("halt_mid_fetch_rdata", 70'(i_rdata), 70'h7E7E);
    halt = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
